queue_dispatcher: RTL and testbench

Consumer-side counterpart of the EDF `Scheduler`: takes the scheduler's `id`/`enable` grant, drains the granted queue's transaction beat by beat onto a single downstream valid/ready port, and returns the one-cycle `consumed` pulse the scheduler needs to re-arbitrate. Sits between the per-core packet queues and the memory-side master port in MemorEDF.

---
 rtl/queue_dispatcher.sv | 153 +++++++++++++++
 tb/tb_queue_dispatcher.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : queue_dispatcher
// Brief    : Drains the scheduler-granted queue onto one valid/ready port and
//            pulses `consumed` once the transaction's last beat is accepted.
//            Optional watchdog build: define QUEUE_DISPATCHER_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module queue_dispatcher #(
    parameter  int NB_QUEUES  = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 256,
    localparam int ID_WIDTH   = $clog2(NB_QUEUES)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [ID_WIDTH-1:0]             id,
    input  logic                            enable,
    input  logic [NB_QUEUES-1:0]            empty,
    input  logic [NB_QUEUES-1:0]            lastElem,
    input  logic [NB_QUEUES*DATA_WIDTH-1:0] dataIn,
    output logic [NB_QUEUES-1:0]            pop,
    output logic                            m_valid,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_last,
    output logic [ID_WIDTH-1:0]             m_id,
    input  logic                            m_ready,
    output logic                            consumed,
    output logic                            timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ID_WIDTH-1:0] cur_id;
    logic                last_popped;
    logic                slot_free;
    logic                grant_ok;
    logic                do_pop;
    logic                wd_expire;

    assign slot_free = !m_valid || m_ready;
    assign grant_ok  = enable && (32'(id) < NB_QUEUES) && !empty[id];
    // Once the final beat has left the queue, the next head belongs to another transaction.
    assign do_pop    = (state == SEND) && slot_free && !empty[cur_id] && !last_popped;
    assign consumed  = (state == DONE);

    always_comb begin
        pop = '0;
        if (do_pop) begin
            pop[cur_id] = 1'b1;
        end
    end

`ifdef QUEUE_DISPATCHER_WATCHDOG_EN
    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

    logic [WD_WIDTH-1:0] wd_cnt;
    logic                wd_flag;

    assign wd_expire = (state == SEND) && !m_valid && !do_pop &&
                       (wd_cnt == WD_WIDTH'(TIMEOUT - 1));
    assign timeout   = wd_flag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt  <= '0;
            wd_flag <= 1'b0;
        end else begin
            if ((state != SEND) || do_pop) begin
                wd_cnt <= '0;
            end else if (!m_valid) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) begin
                wd_flag <= 1'b1;
            end
        end
    end
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                if (m_valid && m_ready && m_last) begin
                    next_state = DONE;
                end else if (wd_expire) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_id      <= '0;
            last_popped <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            m_id        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        cur_id      <= id;
                        last_popped <= 1'b0;
                    end
                end
                SEND: begin
                    if (do_pop) begin
                        m_valid     <= 1'b1;
                        m_data      <= dataIn[cur_id*DATA_WIDTH +: DATA_WIDTH];
                        m_last      <= lastElem[cur_id];
                        m_id        <= cur_id;
                        last_popped <= lastElem[cur_id];
                    end else if (slot_free) begin
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_queue_dispatcher.sv
`default_nettype none
// Bench for queue_dispatcher: modelled queues feed the DUT, a scoreboard of
// expected beats is filled when each transaction is launched.
module tb_queue_dispatcher;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int IW = 2;
`ifdef QUEUE_DISPATCHER_WATCHDOG_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif

    logic             clock    = 1'b0;
    logic             reset    = 1'b0;
    logic [IW-1:0]    id       = '0;
    logic             enable   = 1'b0;
    logic [NB-1:0]    empty    = '1;
    logic [NB-1:0]    lastElem = '0;
    logic [NB*DW-1:0] dataIn   = '0;
    logic [NB-1:0]    pop;
    logic             m_valid;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic [IW-1:0]    m_id;
    logic             m_ready  = 1'b1;
    logic             consumed;
    logic             timeout;

    queue_dispatcher #(
        .NB_QUEUES (NB),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .id      (id),
        .enable  (enable),
        .empty   (empty),
        .lastElem(lastElem),
        .dataIn  (dataIn),
        .pop     (pop),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_id    (m_id),
        .m_ready (m_ready),
        .consumed(consumed),
        .timeout (timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [IW-1:0] q;
    } exp_t;

    typedef struct {
        int q;
        int nbeats;
        int stall_beat;
        int stall_cyc;
        bit switch_id;
        int gap_after;
        int gap_len;
        int rst_after;
        int exp_pops;
        int exp_cons;
    } vec_t;

    beat_t mq[NB][$];
    exp_t  sb[$];
    vec_t  tbl[7];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q = -1;
    int n_pops = 0;
    int n_cons = 0;
    int hs_count = 0;
    int first_pop_cyc = -1;
    int last_hs_cyc = -1;
    int cons_cyc = -1;
    bit wd_mode = 1'b0;
    bit prev_hold = 1'b0;
    logic [DW+IW+1:0] prev_beat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NB; i++) begin
            empty[i]             = (mq[i].size() == 0);
            lastElem[i]          = (mq[i].size() > 0) ? mq[i][0].l : 1'b0;
            dataIn[i*DW +: DW]   = (mq[i].size() > 0) ? mq[i][0].d : '0;
        end
    endtask

    // One clock cycle: drive queue heads, sample just before the rising edge.
    task automatic tick();
        exp_t          e;
        logic [NB-1:0] ep;
        refresh();
        #1;
        if (pop != '0) begin
            ep = (exp_q >= 0) ? (4'b0001 << exp_q) : 4'b0000;
            chk("pop_target", pop, ep);
            for (int i = 0; i < NB; i++) begin
                if (pop[i] && mq[i].size() > 0) mq[i].delete(0);
            end
            n_pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (prev_hold) chk("hold_stable", {m_valid, m_data, m_last, m_id}, prev_beat);
        prev_hold = m_valid && !m_ready;
        prev_beat = {m_valid, m_data, m_last, m_id};
        if (m_valid && m_ready) begin
            chk("beat_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("beat_data", m_data, e.d);
                chk("beat_last", m_last, e.l);
                chk("beat_id", m_id, e.q);
            end
            hs_count++;
            last_hs_cyc = cyc;
        end
        if (consumed) begin
            n_cons++;
            cons_cyc = cyc;
            if (!wd_mode) chk("consumed_after_last", cyc, last_hs_cyc + 1);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NB; i++) mq[i].delete();
        sb.delete();
        exp_q = -1;
    endtask

    task automatic run_txn(input vec_t v);
        beat_t b[$];
        beat_t x;
        exp_t  e;
        int    stall_left;
        int    gap_cnt;
        int    g;
        bit    done;
        bit    refilled;
        b = {};
        for (int k = 0; k < v.nbeats; k++) begin
            x.d = $urandom;
            x.l = (k == v.nbeats - 1);
            b.push_back(x);
            e.d = x.d;
            e.l = x.l;
            e.q = IW'(v.q);
            sb.push_back(e);
        end
        for (int k = 0; k < ((v.gap_after > 0) ? v.gap_after : v.nbeats); k++) mq[v.q].push_back(b[k]);
        for (int i = 0; i < NB; i++) begin
            if (i != v.q && mq[i].size() == 0) begin
                x.d = $urandom;
                x.l = 1'b1;
                mq[i].push_back(x);
            end
        end
        n_pops = 0; n_cons = 0; hs_count = 0;
        first_pop_cyc = -1; cons_cyc = -1; last_hs_cyc = -1;
        exp_q = v.q; stall_left = v.stall_cyc; gap_cnt = 0;
        refilled = (v.gap_after == 0); done = 1'b0;
        id = IW'(v.q); enable = 1'b1; m_ready = 1'b1;
        g = cyc;
        tick();
        if (v.switch_id) id = 2'd3;
        else enable = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (v.rst_after > 0 && hs_count == v.rst_after) begin
                reset = 1'b0;
                #1;
                chk("rst_mid_outputs", {pop, m_valid, m_data, m_last, m_id, consumed, timeout}, 64'd0);
                sb.delete();
                mq[v.q].delete();
                exp_q = -1;
                prev_hold = 1'b0;
                tick();
                reset = 1'b1;
                done = 1'b1;
            end else begin
                if (!refilled && hs_count >= v.gap_after) begin
                    chk("gap_valid_low", m_valid, 0);
                    gap_cnt++;
                    if (gap_cnt > v.gap_len) begin
                        for (int k = v.gap_after; k < v.nbeats; k++) mq[v.q].push_back(b[k]);
                        refilled = 1'b1;
                    end
                end
                m_ready = !(m_valid && (hs_count == v.stall_beat - 1) && stall_left > 0);
                if (!m_ready) stall_left--;
                tick();
                if (n_cons > 0) done = 1'b1;
            end
        end
        chk("txn_done", done, 1);
        enable = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        chk("pop_count", n_pops, v.exp_pops);
        chk("consumed_count", n_cons, v.exp_cons);
        chk("first_pop_latency", first_pop_cyc - g, 1);
        if (v.exp_cons > 0) chk("sb_drained", sb.size(), 0);
        if (v.nbeats == 1 && v.stall_cyc == 0) chk("grant_to_consumed", cons_cyc - g, 3);
        clear_model();
    endtask

`ifdef QUEUE_DISPATCHER_WATCHDOG_EN
    task automatic run_watchdog();
        beat_t x;
        exp_t  e;
        x.d = $urandom;
        x.l = 1'b0;
        mq[0].push_back(x);
        e.d = x.d; e.l = 1'b0; e.q = '0;
        sb.push_back(e);
        wd_mode = 1'b1;
        exp_q = 0; n_cons = 0; hs_count = 0; cons_cyc = -1; last_hs_cyc = -1;
        id = '0; enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int c = 0; c < 40 && n_cons == 0; c++) tick();
        chk("wd_consumed_delay", cons_cyc - last_hs_cyc, TMO + 1);
        tick();
        tick();
        chk("wd_consumed_count", n_cons, 1);
        chk("wd_timeout_sticky", timeout, 1);
        reset = 1'b0;
        #1;
        chk("wd_timeout_reset", timeout, 0);
        tick();
        reset = 1'b1;
        wd_mode = 1'b0;
        clear_model();
    endtask
`endif

    initial begin
        beat_t x;
        tbl[0] = '{2, 1, 0, 0, 1'b0, 0, 0, 0, 1, 1};
        tbl[1] = '{1, 4, 2, 3, 1'b0, 0, 0, 0, 4, 1};
        tbl[2] = '{0, 3, 0, 0, 1'b1, 0, 0, 0, 3, 1};
        tbl[3] = '{0, 3, 0, 0, 1'b0, 1, 4, 0, 3, 1};
        tbl[4] = '{2, 4, 0, 0, 1'b0, 0, 0, 2, 3, 0};
        tbl[5] = '{1, 1, 0, 0, 1'b0, 0, 0, 0, 1, 1};
        tbl[6] = '{3, 5, 1, 2, 1'b0, 0, 0, 0, 5, 1};

        // Reset held with random inputs: every output must read zero.
        for (int r = 0; r < 4; r++) begin
            {id, enable, empty, lastElem, m_ready} = 12'($urandom);
            for (int i = 0; i < NB; i++) dataIn[i*DW +: DW] = $urandom;
            #1;
            chk("reset_outputs", {pop, m_valid, m_data, m_last, m_id, consumed, timeout}, 64'd0);
            @(negedge clock);
        end
        enable = 1'b0;
        m_ready = 1'b1;
        reset = 1'b1;

        // Idle with full queues and no grant: no pop.
        for (int i = 0; i < NB; i++) begin
            x.d = $urandom;
            x.l = 1'b1;
            mq[i].push_back(x);
        end
        exp_q = -1; n_pops = 0; n_cons = 0;
        repeat (4) tick();
        chk("idle_no_pop", n_pops, 0);
        chk("idle_valid", m_valid, 0);

        // Grant on an empty queue is ignored.
        mq[1].delete();
        id = 2'd1;
        enable = 1'b1;
        repeat (3) tick();
        enable = 1'b0;
        chk("empty_grant_no_pop", n_pops, 0);
        chk("empty_grant_no_consumed", n_cons, 0);
        clear_model();
        tick();

        for (int t = 0; t < 7; t++) run_txn(tbl[t]);

`ifdef QUEUE_DISPATCHER_WATCHDOG_EN
        run_watchdog();
`else
        chk("timeout_tied_low", timeout, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
